color_fsm_steering_driver: RTL and testbench

Closed-loop stimulus master for the switch-driven RGB Moore colour FSM. It drives SW1/SW0 and reads back the one-hot R/B/G outputs. On a handshaked request it steers the colour FSM from its observed colour to a requested target colour, one switch code per step, and checks every transition against a built-in model of the FSM. It is used in board self-test and as the driver side of the colour FSM in integration benches.

---
 rtl/color_fsm_pkg.sv | 86 ++++++++
 rtl/color_fsm_steering_driver_planner.sv | 21 ++
 rtl/color_fsm_steering_driver.sv | 129 ++++++++++++
 tb/tb_color_fsm_steering_driver.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/color_fsm_pkg.sv
// Shared colour encodings, error codes and the colour FSM plant model used
// by the steering driver and its step planner.
package color_fsm_pkg;

  localparam logic [1:0] RED       = 2'd0;
  localparam logic [1:0] BLUE      = 2'd1;
  localparam logic [1:0] GREEN     = 2'd2;
  localparam logic [1:0] NON_COLOR = 2'd3;

  localparam logic [1:0] ERR_NONE        = 2'd0;
  localparam logic [1:0] ERR_UNREACHABLE = 2'd1;
  localparam logic [1:0] ERR_MISMATCH    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT     = 2'd3;

  typedef struct packed {
    logic       illegal;
    logic [1:0] color;
  } obs_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STEP   = 2'd1,
    ST_VERIFY = 2'd2
  } state_t;

  // Illegal one-hot patterns still report NON_COLOR on the colour field.
  function automatic obs_t decode_rgb(input logic r, input logic b, input logic g);
    obs_t o;
    o.illegal = 1'b0;
    o.color   = NON_COLOR;
    case ({r, b, g})
      3'b100:  o.color = RED;
      3'b010:  o.color = BLUE;
      3'b001:  o.color = GREEN;
      3'b000:  o.color = NON_COLOR;
      default: o.illegal = 1'b1;
    endcase
    return o;
  endfunction

  function automatic logic [1:0] next_color(input logic [1:0] c, input logic [1:0] sw);
    logic [1:0] n;
    case (c)
      RED:     n = sw[1] ? RED : (sw[0] ? BLUE : NON_COLOR);
      BLUE:    n = sw[1] ? RED : BLUE;
      GREEN: begin
        case (sw)
          2'b00:   n = GREEN;
          2'b01:   n = RED;
          2'b10:   n = BLUE;
          default: n = NON_COLOR;
        endcase
      end
      default: n = sw[1] ? (sw[0] ? RED : BLUE) : NON_COLOR;
    endcase
    return n;
  endfunction

  function automatic logic [1:0] hold_code(input logic [1:0] c);
    return (c == RED) ? 2'b10 : 2'b00;
  endfunction

  // GREEN is unreachable from any other colour, so it only ever holds.
  function automatic logic [1:0] step_code(input logic [1:0] obs, input logic [1:0] tgt);
    logic [1:0] s;
    s = hold_code(obs);
    case (tgt)
      RED: s = 2'b11;
      BLUE: begin
        if (obs == RED)       s = 2'b01;
        else if (obs != BLUE) s = 2'b10;
      end
      NON_COLOR: begin
        case (obs)
          RED:     s = 2'b00;
          BLUE:    s = 2'b10;
          GREEN:   s = 2'b11;
          default: s = 2'b00;
        endcase
      end
      default: s = hold_code(obs);
    endcase
    return s;
  endfunction

endpackage

// File: rtl/color_fsm_steering_driver_planner.sv
// Combinational step planner: picks the next switch code toward the target
// and predicts the colour the FSM should land on.
module color_step_planner
  import color_fsm_pkg::*;
(
  input  logic [1:0] obs_i,
  input  logic [1:0] target_i,
  output logic [1:0] step_o,
  output logic [1:0] pred_o,
  output logic       at_target_o,
  output logic       unreachable_o
);

  always_comb begin
    step_o        = step_code(obs_i, target_i);
    pred_o        = next_color(obs_i, step_o);
    at_target_o   = (obs_i == target_i);
    unreachable_o = (target_i == GREEN) && (obs_i != GREEN);
  end

endmodule

// File: rtl/color_fsm_steering_driver.sv
// Closed-loop driver that steers the RGB colour FSM to a requested colour,
// checking each observed transition against the plant model.
module color_fsm_steering_driver
  import color_fsm_pkg::*;
#(
  parameter int MAX_STEPS  = 4,
  parameter int STEP_CNT_W = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [1:0] req_color,
  output logic       req_ready,
  output logic       SW0,
  output logic       SW1,
  input  logic       R,
  input  logic       B,
  input  logic       G,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code,
  output logic [1:0] cur_color
);

  localparam logic [STEP_CNT_W-1:0] MAX_CNT = STEP_CNT_W'(MAX_STEPS);

  state_t                state_q;
  logic [1:0]            sw_q;
  logic [1:0]            pred_q;
  logic [1:0]            target_q;
  logic [1:0]            err_code_q;
  logic [STEP_CNT_W-1:0] cnt_q;
  logic                  done_q;
  logic                  error_q;

  obs_t       obs;
  logic [1:0] plan_tgt;
  logic [1:0] plan_step;
  logic [1:0] plan_pred;
  logic       plan_at_tgt;
  logic       plan_unreach;

  assign obs      = decode_rgb(R, B, G);
  // Fresh requests plan against the incoming colour; mid-request uses the latched one.
  assign plan_tgt = (state_q == ST_IDLE) ? req_color : target_q;

  color_step_planner u_planner (
    .obs_i         (obs.color),
    .target_i      (plan_tgt),
    .step_o        (plan_step),
    .pred_o        (plan_pred),
    .at_target_o   (plan_at_tgt),
    .unreachable_o (plan_unreach)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      sw_q       <= 2'b10;
      pred_q     <= RED;
      target_q   <= RED;
      err_code_q <= ERR_NONE;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          sw_q <= hold_code(obs.color);
          if (req_valid) begin
            target_q <= req_color;
            if (obs.illegal) begin
              error_q    <= 1'b1;
              err_code_q <= ERR_MISMATCH;
            end else if (plan_at_tgt) begin
              done_q <= 1'b1;
            end else if (plan_unreach) begin
              error_q    <= 1'b1;
              err_code_q <= ERR_UNREACHABLE;
            end else begin
              sw_q    <= plan_step;
              pred_q  <= plan_pred;
              cnt_q   <= STEP_CNT_W'(1);
              state_q <= ST_STEP;
            end
          end
        end
        // The colour FSM samples the step code on this edge; park on its hold code.
        ST_STEP: begin
          sw_q    <= hold_code(pred_q);
          state_q <= ST_VERIFY;
        end
        ST_VERIFY: begin
          if (obs.illegal || (obs.color != pred_q)) begin
            error_q    <= 1'b1;
            err_code_q <= ERR_MISMATCH;
            state_q    <= ST_IDLE;
          end else if (plan_at_tgt) begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else if (cnt_q == MAX_CNT) begin
            error_q    <= 1'b1;
            err_code_q <= ERR_TIMEOUT;
            state_q    <= ST_IDLE;
          end else begin
            sw_q    <= plan_step;
            pred_q  <= plan_pred;
            cnt_q   <= cnt_q + 1'b1;
            state_q <= ST_STEP;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign SW1       = sw_q[1];
  assign SW0       = sw_q[0];
  assign done      = done_q;
  assign error     = error_q;
  assign err_code  = err_code_q;
  assign cur_color = obs.color;

endmodule

// File: tb/tb_color_fsm_steering_driver.sv
// Bench for color_fsm_steering_driver: behavioural colour FSM plants driven by
// a default instance and a MAX_STEPS=1 instance, table vectors plus corner cases.
module tb_color_fsm_steering_driver;
  import color_fsm_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic [1:0] req_color = 2'd0;

  logic       req_ready, sw0, sw1, busy, done, error;
  logic [1:0] err_code, cur_color;
  logic       t_req_ready, t_sw0, t_sw1, t_busy, t_done, t_error;
  logic [1:0] t_err_code, t_cur_color;

  logic [1:0] plant_q, plant_t_q;
  logic [1:0] plant_val = 2'd0;
  logic       plant_ld = 1'b1;
  logic       b_stuck = 1'b0;
  logic       r, b, g, tr, tb, tg;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Plant transition table indexed by {colour, SW1, SW0}.
  function automatic logic [1:0] pnext(input logic [1:0] c, input logic [1:0] sw);
    logic [3:0] idx;
    logic [1:0] n;
    idx = {c, sw};
    case (idx)
      4'h0: n = 2'd3;  4'h1: n = 2'd1;  4'h2: n = 2'd0;  4'h3: n = 2'd0;
      4'h4: n = 2'd1;  4'h5: n = 2'd1;  4'h6: n = 2'd0;  4'h7: n = 2'd0;
      4'h8: n = 2'd2;  4'h9: n = 2'd0;  4'hA: n = 2'd1;  4'hB: n = 2'd3;
      4'hC: n = 2'd3;  4'hD: n = 2'd3;  4'hE: n = 2'd1;  default: n = 2'd0;
    endcase
    return n;
  endfunction

  always @(posedge clk) begin
    plant_q   <= plant_ld ? plant_val : pnext(plant_q, {sw1, sw0});
    plant_t_q <= plant_ld ? plant_val : pnext(plant_t_q, {t_sw1, t_sw0});
  end

  assign r  = (plant_q == 2'd0);
  assign b  = (plant_q == 2'd1) && !b_stuck;
  assign g  = (plant_q == 2'd2);
  assign tr = (plant_t_q == 2'd0);
  assign tb = (plant_t_q == 2'd1);
  assign tg = (plant_t_q == 2'd2);

  color_fsm_steering_driver dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_color(req_color),
    .req_ready(req_ready), .SW0(sw0), .SW1(sw1), .R(r), .B(b), .G(g),
    .busy(busy), .done(done), .error(error), .err_code(err_code), .cur_color(cur_color)
  );

  color_fsm_steering_driver #(.MAX_STEPS(1), .STEP_CNT_W(1)) dut_t (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_color(req_color),
    .req_ready(t_req_ready), .SW0(t_sw0), .SW1(t_sw1), .R(tr), .B(tb), .G(tg),
    .busy(t_busy), .done(t_done), .error(t_error), .err_code(t_err_code), .cur_color(t_cur_color)
  );

  typedef struct {
    logic [1:0] init;
    logic [1:0] tgt;
    logic       stuck;
    int         done_c;
    int         err_c;
    logic [1:0] code;
    logic [1:0] cur;
    logic [7:0] sw;
    int         t_done;
    int         t_err;
    logic [1:0] t_code;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_plant(input logic [1:0] c, input logic stuck);
    b_stuck   = stuck;
    plant_val = c;
    plant_ld  = 1'b1;
    repeat (3) @(posedge clk);
    #1 plant_ld = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int i);
    int nd, ne, dc, ec, tnd, tne, tdc, tec;
    logic [1:0] code_at, tcode_at;
    logic bz;
    logic [7:0] swseq;
    nd = 0; ne = 0; dc = 0; ec = 0; tnd = 0; tne = 0; tdc = 0; tec = 0;
    code_at = 2'd0; tcode_at = 2'd0; bz = 1'b0; swseq = 8'd0;
    load_plant(vecs[i].init, vecs[i].stuck);
    req_color = vecs[i].tgt;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
      end
      if (k <= 4) swseq = {swseq[5:0], sw1, sw0};
      if (busy) bz = 1'b1;
      if (done) begin nd++; dc = k; end
      if (error) begin ne++; ec = k; code_at = err_code; end
      if (t_done) begin tnd++; tdc = k; end
      if (t_error) begin tne++; tec = k; tcode_at = t_err_code; end
    end
    chk($sformatf("v%0d done_cycle", i), dc, vecs[i].done_c);
    chk($sformatf("v%0d done_count", i), nd, (vecs[i].done_c != 0) ? 1 : 0);
    chk($sformatf("v%0d err_cycle", i), ec, vecs[i].err_c);
    chk($sformatf("v%0d err_count", i), ne, (vecs[i].err_c != 0) ? 1 : 0);
    if (vecs[i].err_c != 0) chk($sformatf("v%0d err_code", i), code_at, vecs[i].code);
    chk($sformatf("v%0d cur_color", i), cur_color, vecs[i].cur);
    chk($sformatf("v%0d sw_seq", i), swseq, vecs[i].sw);
    chk($sformatf("v%0d busy_seen", i), bz, (vecs[i].done_c > 1) || (vecs[i].err_c > 1));
    chk($sformatf("v%0d t_done_cycle", i), tdc, vecs[i].t_done);
    chk($sformatf("v%0d t_err_cycle", i), tec, vecs[i].t_err);
    if (vecs[i].t_err != 0) chk($sformatf("v%0d t_err_code", i), tcode_at, vecs[i].t_code);
  endtask

  initial begin
    logic [1:0] last_code;
    int nd, ne, dc;
    // init tgt stuck done err code cur sw t_done t_err t_code
    vecs[0]  = '{RED,       BLUE,      1'b0, 3, 0, 2'd0, BLUE,      8'b01_00_00_00, 3, 0, 2'd0};
    vecs[1]  = '{BLUE,      NON_COLOR, 1'b0, 5, 0, 2'd0, NON_COLOR, 8'b10_10_00_00, 0, 3, 2'd3};
    vecs[2]  = '{RED,       GREEN,     1'b0, 0, 1, 2'd1, RED,       8'b10_10_10_10, 0, 1, 2'd1};
    vecs[3]  = '{RED,       RED,       1'b0, 1, 0, 2'd0, RED,       8'b10_10_10_10, 1, 0, 2'd0};
    vecs[4]  = '{RED,       BLUE,      1'b1, 0, 3, 2'd2, NON_COLOR, 8'b01_00_00_00, 3, 0, 2'd0};
    vecs[5]  = '{NON_COLOR, RED,       1'b0, 3, 0, 2'd0, RED,       8'b11_10_10_10, 3, 0, 2'd0};
    vecs[6]  = '{GREEN,     BLUE,      1'b0, 3, 0, 2'd0, BLUE,      8'b10_00_00_00, 3, 0, 2'd0};
    vecs[7]  = '{GREEN,     NON_COLOR, 1'b0, 3, 0, 2'd0, NON_COLOR, 8'b11_00_00_00, 3, 0, 2'd0};
    vecs[8]  = '{GREEN,     RED,       1'b0, 5, 0, 2'd0, RED,       8'b11_00_11_10, 0, 3, 2'd3};
    vecs[9]  = '{NON_COLOR, BLUE,      1'b0, 3, 0, 2'd0, BLUE,      8'b10_00_00_00, 3, 0, 2'd0};
    vecs[10] = '{BLUE,      RED,       1'b0, 3, 0, 2'd0, RED,       8'b11_10_10_10, 3, 0, 2'd0};
    vecs[11] = '{GREEN,     GREEN,     1'b0, 1, 0, 2'd0, GREEN,     8'b00_00_00_00, 1, 0, 2'd0};
    vecs[12] = '{NON_COLOR, GREEN,     1'b0, 0, 1, 2'd1, NON_COLOR, 8'b00_00_00_00, 0, 1, 2'd1};
    vecs[13] = '{BLUE,      BLUE,      1'b0, 1, 0, 2'd0, BLUE,      8'b00_00_00_00, 1, 0, 2'd0};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst SW1", sw1, 1'b1);
    chk("rst SW0", sw0, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst error", error, 1'b0);
    chk("rst err_code", err_code, 2'd0);
    chk("rst req_ready", req_ready, 1'b1);
    reset = 1'b0;

    last_code = 2'd0;
    for (int i = 0; i < 14; i++) begin
      run_vec(i);
      if (vecs[i].err_c != 0) last_code = vecs[i].code;
    end
    chk("err_code_hold", err_code, last_code);

    // Requests while busy are ignored.
    load_plant(RED, 1'b0);
    req_color = BLUE;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_color = GREEN;
    chk("busy_ready_low", req_ready, 1'b0);
    nd = 0; ne = 0; dc = 0;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
      end
      if (k == 3) req_valid = 1'b0;
      if (done) begin nd++; dc = k; end
      if (error) ne++;
    end
    chk("ignore done_cycle", dc, 3);
    chk("ignore done_count", nd, 1);
    chk("ignore err_count", ne, 0);
    chk("ignore cur_color", cur_color, BLUE);

    // Asynchronous reset during STEP aborts with no pulse.
    load_plant(RED, 1'b0);
    req_color = BLUE;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("step busy", busy, 1'b1);
    chk("step sw", {sw1, sw0}, 2'b01);
    reset = 1'b1;
    #1;
    chk("async SW1", sw1, 1'b1);
    chk("async SW0", sw0, 1'b0);
    chk("async busy", busy, 1'b0);
    nd = 0; ne = 0;
    for (int k = 0; k < 6; k++) begin
      if (done || error || t_done || t_error) begin
        nd += int'(done) + int'(t_done);
        ne += int'(error) + int'(t_error);
      end
      if (k == 2) reset = 1'b0;
      @(posedge clk);
      #1;
    end
    chk("abort done_count", nd, 0);
    chk("abort err_count", ne, 0);
    chk("abort busy", busy, 1'b0);
    chk("abort cur_color", cur_color, RED);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
